// File: rtl/conversor_bin_bcd_secuencial.sv
// -----------------------------------------------------------------------------
// conversor_bin_bcd_secuencial
//
// Multi-cycle binary-to-BCD converter using iterative shift add-3 (double
// dabble), one input bit per clock. It sits between funcionMatematica and
// display7Seg. salidaBCD holds the last result steady for the display
// multiplexer until the next conversion completes.
//
// Parameters
//   ANCHO_BIN   width of the binary input
//   DIGITOS     number of BCD digits; 10**DIGITOS must exceed 2**ANCHO_BIN-1
//
// Ports
//   clkNexys2   in   system clock, all logic on the rising edge
//   Reset       in   synchronous, active-high reset (aborts any conversion)
//   inicio      in   start request, only looked at while idle
//   numBinario  in   binary value, captured on the accepting edge
//   ocupado     out  high while a conversion is in progress
//   listo       out  one-cycle pulse, salidaBCD has just been updated
//   salidaBCD   out  BCD digits, [3:0]=unidades, [7:4]=decenas, ...
//
// Optional feature (macro AUTO_INICIO_EN)
//   When defined, the last accepted input is remembered in ultimo_q and an
//   idle block starts by itself whenever numBinario differs from it, so the
//   display follows the input without any inicio pulse.
//
// FSM states
//   state        | meaning
//   REPOSO       | idle, result held, waiting for a start
//   CONVIRTIENDO | one add-3/shift iteration per clock
// -----------------------------------------------------------------------------
module conversor_bin_bcd_secuencial #(
  parameter int ANCHO_BIN = 8,
  parameter int DIGITOS   = 3
) (
  input  logic                   clkNexys2,
  input  logic                   Reset,
  input  logic                   inicio,
  input  logic [ANCHO_BIN-1:0]   numBinario,
  output logic                   ocupado,
  output logic                   listo,
  output logic [4*DIGITOS-1:0]   salidaBCD
);

  localparam int ANCHO_BCD = 4 * DIGITOS;
  localparam int ANCHO_SR  = ANCHO_BCD + ANCHO_BIN;
  localparam int ANCHO_CNT = $clog2(ANCHO_BIN + 1);
  localparam logic [ANCHO_CNT-1:0] CNT_INI = ANCHO_CNT'(ANCHO_BIN);
  localparam logic [ANCHO_CNT-1:0] CNT_FIN = ANCHO_CNT'(1);

  function automatic longint unsigned pot10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned ESCALA  = pot10(DIGITOS);
  localparam longint unsigned MAX_BIN = (longint'(1) << ANCHO_BIN) - 1;

  generate
    if (ESCALA <= MAX_BIN) begin : g_param_invalido
      $error("conversor_bin_bcd_secuencial: DIGITOS too small for ANCHO_BIN");
    end
  endgenerate

  typedef enum logic {
    REPOSO       = 1'b0,
    CONVIRTIENDO = 1'b1
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [ANCHO_BCD-1:0]   bcd_q, bcd_d;
  logic [ANCHO_BIN-1:0]   bin_q, bin_d;
  logic [ANCHO_CNT-1:0]   cnt_q, cnt_d;
  logic [ANCHO_BCD-1:0]   salida_q, salida_d;
  logic                   ocupado_q, ocupado_d;
  logic                   listo_q, listo_d;

  logic                   arranque;
  logic [ANCHO_BCD-1:0]   bcd_aj;
  logic [ANCHO_SR-1:0]    desplazado;

`ifdef AUTO_INICIO_EN
  logic [ANCHO_BIN-1:0]   ultimo_q, ultimo_d;
  assign arranque = inicio || (numBinario != ultimo_q);
`else
  assign arranque = inicio;
`endif

  // Add-3 correction on the pre-shift digits, all nibbles in parallel. A digit
  // is at most 9 here, so the 4-bit sum never exceeds 12 and needs no carry.
  always_comb begin
    bcd_aj = bcd_q;
    for (int i = 0; i < DIGITOS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_aj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // The binary MSB moves into the BCD units digit on each shift.
  assign desplazado = {bcd_aj, bin_q} << 1;

  always_comb begin
    estado_d  = estado_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    salida_d  = salida_q;
    ocupado_d = ocupado_q;
    listo_d   = 1'b0;
`ifdef AUTO_INICIO_EN
    ultimo_d  = ultimo_q;
`endif

    unique case (estado_q)
      REPOSO: begin
        if (arranque) begin
          bin_d     = numBinario;
          bcd_d     = '0;
          cnt_d     = CNT_INI;
          ocupado_d = 1'b1;
          estado_d  = CONVIRTIENDO;
`ifdef AUTO_INICIO_EN
          ultimo_d  = numBinario;
`endif
        end
      end

      CONVIRTIENDO: begin
        bcd_d = desplazado[ANCHO_SR-1 -: ANCHO_BCD];
        bin_d = desplazado[ANCHO_BIN-1:0];
        cnt_d = cnt_q - CNT_FIN;
        if (cnt_q == CNT_FIN) begin
          salida_d  = desplazado[ANCHO_SR-1 -: ANCHO_BCD];
          listo_d   = 1'b1;
          ocupado_d = 1'b0;
          estado_d  = REPOSO;
        end
      end

      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  always_ff @(posedge clkNexys2) begin
    if (Reset) begin
      estado_q  <= REPOSO;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      salida_q  <= '0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
`ifdef AUTO_INICIO_EN
      ultimo_q  <= '0;
`endif
    end else begin
      estado_q  <= estado_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      salida_q  <= salida_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
`ifdef AUTO_INICIO_EN
      ultimo_q  <= ultimo_d;
`endif
    end
  end

  assign ocupado   = ocupado_q;
  assign listo     = listo_q;
  assign salidaBCD = salida_q;

endmodule

// File: tb/tb_conversor_bin_bcd_secuencial.sv
// -----------------------------------------------------------------------------
// tb_conversor_bin_bcd_secuencial
//
// Directed bench for conversor_bin_bcd_secuencial with default parameters.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conversor_bin_bcd_secuencial;

  logic        clk;
  logic        rst;
  logic        inicio;
  logic [7:0]  num;
  logic        ocupado;
  logic        listo;
  logic [11:0] bcd;

  int n_checks = 0;
  int n_fail   = 0;

  conversor_bin_bcd_secuencial #(
    .ANCHO_BIN (8),
    .DIGITOS   (3)
  ) dut (
    .clkNexys2  (clk),
    .Reset      (rst),
    .inicio     (inicio),
    .numBinario (num),
    .ocupado    (ocupado),
    .listo      (listo),
    .salidaBCD  (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one conversion and check latency and the final digits.
  task automatic run_conv(input string tag, input logic [7:0] v, input logic [11:0] e);
    int early;
    early = 0;
    num    = v;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    chk({tag, "_ocupado"}, {31'd0, ocupado}, 32'd1);
    for (int k = 0; k < 7; k++) begin
      tick();
      if (listo !== 1'b0 || ocupado !== 1'b1) early++;
    end
    chk({tag, "_early"}, early, 32'd0);
    tick();
    chk({tag, "_listo"}, {31'd0, listo}, 32'd1);
    chk({tag, "_bcd"}, {20'd0, bcd}, {20'd0, e});
  endtask

  int extra;
  int busy;

  initial begin
    rst    = 1'b1;
    inicio = 1'b0;
    num    = 8'd0;
    @(negedge clk);

    // 1: reset
    tick();
    tick();
    chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("rst_listo",   {31'd0, listo},   32'd0);
    chk("rst_bcd",     {20'd0, bcd},     32'h000);
    rst = 1'b0;
    tick();
    chk("idle_ocupado", {31'd0, ocupado}, 32'd0);
    chk("idle_bcd",     {20'd0, bcd},     32'h000);

    // 2: full scale, ocupado high for exactly 8 cycles
    num    = 8'hFF;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    busy = 0;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      if (ocupado === 1'b1) busy++;
      if (listo !== 1'b0) extra++;
      if (k < 7) tick();
    end
    chk("ff_busy_cycles", busy, 32'd8);
    chk("ff_no_early_listo", extra, 32'd0);
    tick();
    chk("ff_listo",   {31'd0, listo},   32'd1);
    chk("ff_ocupado", {31'd0, ocupado}, 32'd0);
    chk("ff_bcd",     {20'd0, bcd},     32'h255);
    tick();
    chk("ff_listo_pulse", {31'd0, listo}, 32'd0);
    chk("ff_hold",        {20'd0, bcd},   32'h255);

    // 3: inicio held high, back-to-back every 9 cycles
    num    = 8'd100;
    inicio = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      extra = 0;
      for (int k = 0; k < 7; k++) begin
        tick();
        if (listo !== 1'b0) extra++;
      end
      chk("b2b_gap", extra, 32'd0);
      tick();
      chk("b2b_listo", {31'd0, listo}, 32'd1);
      chk("b2b_bcd",   {20'd0, bcd},   32'h100);
      if (r == 2) inicio = 1'b0;
      tick();
      chk("b2b_listo_drop", {31'd0, listo}, 32'd0);
      chk("b2b_restart", {31'd0, ocupado}, (r < 2) ? 32'd1 : 32'd0);
    end

    // 4: input change and inicio during conversion are ignored
    num    = 8'd57;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick();
    tick();
    num    = 8'd200;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    num    = 8'd57;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_listo", {31'd0, listo}, 32'd1);
    chk("mid_bcd",   {20'd0, bcd},   32'h057);
    extra = 0;
    busy  = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (listo !== 1'b0) extra++;
      if (ocupado !== 1'b0) busy++;
    end
    chk("mid_no_extra_listo", extra, 32'd0);
    chk("mid_no_restart",     busy,  32'd0);
    chk("mid_hold",           {20'd0, bcd}, 32'h057);

    // assorted values, including zero input
    run_conv("zero",  8'd0,   12'h000);
    run_conv("nine",  8'd9,   12'h009);
    run_conv("v128",  8'd128, 12'h128);
    run_conv("v255b", 8'd255, 12'h255);
    run_conv("v199",  8'd199, 12'h199);

    // 5: reset aborts a conversion
    num    = 8'd199;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    num    = 8'd37;
    tick();
    tick();
    tick();
    chk("abort_busy_before", {31'd0, ocupado}, 32'd1);
    rst = 1'b1;
    num = 8'd0;
    tick();
    chk("abort_ocupado", {31'd0, ocupado}, 32'd0);
    chk("abort_bcd",     {20'd0, bcd},     32'h000);
    chk("abort_listo",   {31'd0, listo},   32'd0);
    rst = 1'b0;
    extra = 0;
    busy  = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (listo !== 1'b0) extra++;
      if (ocupado !== 1'b0) busy++;
    end
    chk("abort_no_listo", extra, 32'd0);
    chk("abort_idle",     busy,  32'd0);
    chk("abort_bcd_hold", {20'd0, bcd}, 32'h000);

`ifdef AUTO_INICIO_EN
    // 6: input change starts a conversion without inicio
    num = 8'd42;
    tick();
    extra = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (listo !== 1'b0) extra++;
    end
    chk("auto_gap", extra, 32'd0);
    tick();
    chk("auto_listo", {31'd0, listo}, 32'd1);
    chk("auto_bcd",   {20'd0, bcd},   32'h042);
    extra = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (listo !== 1'b0) extra++;
    end
    chk("auto_stable", extra, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
